// File: rtl/frame_sequencer_pkg.sv
// Shared types and default widths for the frame sequencer and its scan counter.
package frame_sequencer_pkg;

  localparam int unsigned DefRows        = 4;
  localparam int unsigned DefCols        = 4;
  localparam int unsigned DefRowBits     = 8;
  localparam int unsigned DefColBits     = 8;
  localparam int unsigned DefCoordBits   = 8;
  localparam int unsigned DefPaletteBits = 8;
  localparam int unsigned DefPixelBits   = 8;
  localparam int unsigned DefTimeout     = 255;

  typedef enum logic [3:0] {
    StIdle,
    StRFetch,
    StRLoad,
    StRIssue,
    StRWait,
    StSFetch,
    StSLoad,
    StSIssue,
    StSWait,
    StRdAddr,
    StRdWrite,
    StDone
  } seq_state_e;

  typedef struct packed {
    logic [DefCoordBits-1:0] x;
    logic [DefCoordBits-1:0] y;
    logic [DefCoordBits-1:0] z;
    logic [DefPixelBits-1:0] color;
  } voxel_t;

endpackage

// File: rtl/grid_scan_counter.sv
// Row-major row/col scan counter with wrap and a flag marking the final grid position.
module grid_scan_counter #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned ROW_BITS = 8,
  parameter int unsigned COL_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                advance_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [COL_BITS-1:0] col_o,
  output logic                last_o
);

  logic [ROW_BITS-1:0] row_d, row_q;
  logic [COL_BITS-1:0] col_d, col_q;
  logic                col_wrap;
  logic                row_wrap;

  assign col_wrap = (col_q == COL_BITS'(COLS - 1));
  assign row_wrap = (row_q == ROW_BITS'(ROWS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_wrap && row_wrap;

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one frame: rasterize pass, shade pass, then row-major pixel readout to the framebuffer.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned ROWS         = DefRows,
  parameter int unsigned COLS         = DefCols,
  parameter int unsigned ROW_BITS     = DefRowBits,
  parameter int unsigned COL_BITS     = DefColBits,
  parameter int unsigned COORD_BITS   = DefCoordBits,
  parameter int unsigned PALETTE_BITS = DefPaletteBits,
  parameter int unsigned PIXEL_BITS   = DefPixelBits,
  parameter int unsigned TIMEOUT      = DefTimeout
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [PALETTE_BITS-1:0] num_voxels,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    error,
  output logic                    vox_rd,
  output logic [PALETTE_BITS-1:0] vox_addr,
  input  logic [COORD_BITS-1:0]   vox_x,
  input  logic [COORD_BITS-1:0]   vox_y,
  input  logic [COORD_BITS-1:0]   vox_z,
  input  logic [PIXEL_BITS-1:0]   vox_color,
  output logic                    do_rasterize,
  output logic                    do_shade,
  output logic [COORD_BITS-1:0]   voxel_x,
  output logic [COORD_BITS-1:0]   voxel_y,
  output logic [COORD_BITS-1:0]   voxel_z,
  output logic [PALETTE_BITS-1:0] voxel_id,
  output logic [PIXEL_BITS-1:0]   palette_entry,
  input  logic                    rasterizing_done,
  input  logic                    shading_done,
  output logic [ROW_BITS-1:0]     row,
  output logic [COL_BITS-1:0]     col,
  input  logic [PIXEL_BITS-1:0]   pixel,
  output logic                    fb_valid,
  input  logic                    fb_ready,
  output logic [ROW_BITS-1:0]     fb_row,
  output logic [COL_BITS-1:0]     fb_col,
  output logic [PIXEL_BITS-1:0]   fb_pixel
);

  localparam int unsigned WaitBits = $clog2(TIMEOUT + 1);

  seq_state_e              state_d, state_q;
  logic [PALETTE_BITS-1:0] id_d, id_q, num_d, num_q, id_inc;
  logic [WaitBits-1:0]     wait_d, wait_q;
  logic                    busy_d, busy_q, frame_done_d, frame_done_q, error_d, error_q;
  logic                    vox_rd_d, vox_rd_q, do_rast_d, do_rast_q, do_shade_d, do_shade_q;
  logic [PALETTE_BITS-1:0] vox_addr_d, vox_addr_q, voxel_id_d, voxel_id_q;
  logic [COORD_BITS-1:0]   voxel_x_d, voxel_x_q, voxel_y_d, voxel_y_q, voxel_z_d, voxel_z_q;
  logic [PIXEL_BITS-1:0]   palette_d, palette_q, fb_pixel_d, fb_pixel_q;
  logic                    fb_valid_d, fb_valid_q;
  logic [ROW_BITS-1:0]     fb_row_d, fb_row_q;
  logic [COL_BITS-1:0]     fb_col_d, fb_col_q;
  logic                    in_raster, pass_done, scan_adv, scan_clear, scan_last;

  assign id_inc     = id_q + PALETTE_BITS'(1);
  assign scan_clear = (state_q == StIdle);

  grid_scan_counter #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_scan (
    .clk_i     (clock),
    .rst_i     (reset),
    .clear_i   (scan_clear),
    .advance_i (scan_adv),
    .row_o     (row),
    .col_o     (col),
    .last_o    (scan_last)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    num_d      = num_q;
    wait_d     = wait_q;
    error_d    = error_q;
    voxel_x_d  = voxel_x_q;
    voxel_y_d  = voxel_y_q;
    voxel_z_d  = voxel_z_q;
    voxel_id_d = voxel_id_q;
    palette_d  = palette_q;
    fb_valid_d = fb_valid_q;
    fb_row_d   = fb_row_q;
    fb_col_d   = fb_col_q;
    fb_pixel_d = fb_pixel_q;
    scan_adv   = 1'b0;
    in_raster  = (state_q == StRWait);
    pass_done  = in_raster ? rasterizing_done : shading_done;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_voxels;
          id_d    = '0;
          error_d = 1'b0;
          state_d = (num_voxels != '0) ? StRFetch : StRdAddr;
        end
      end
      StRFetch: state_d = StRLoad;
      StSFetch: state_d = StSLoad;
      StRLoad, StSLoad: begin
        // Read data arrives the cycle after the strobe, i.e. during LOAD.
        voxel_x_d  = vox_x;
        voxel_y_d  = vox_y;
        voxel_z_d  = vox_z;
        voxel_id_d = id_q;
        if (state_q == StSLoad) palette_d = vox_color;
        state_d = (state_q == StRLoad) ? StRIssue : StSIssue;
      end
      StRIssue, StSIssue: begin
        wait_d  = '0;
        state_d = (state_q == StRIssue) ? StRWait : StSWait;
      end
      StRWait, StSWait: begin
        if (pass_done) begin
          if (id_inc == num_q) begin
            id_d    = '0;
            state_d = in_raster ? StSFetch : StRdAddr;
          end else begin
            id_d    = id_inc;
            state_d = in_raster ? StRFetch : StSFetch;
          end
        end else begin
          wait_d = wait_q + WaitBits'(1);
          if (wait_q == WaitBits'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRdAddr: begin
        fb_pixel_d = pixel;
        fb_row_d   = row;
        fb_col_d   = col;
        fb_valid_d = 1'b1;
        state_d    = StRdWrite;
      end
      StRdWrite: begin
        if (fb_ready) begin
          fb_valid_d = 1'b0;
          scan_adv   = 1'b1;
          state_d    = scan_last ? StDone : StRdAddr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so they are registered yet line up with it.
    vox_rd_d     = (state_d == StRFetch) || (state_d == StSFetch);
    vox_addr_d   = vox_rd_d ? id_d : vox_addr_q;
    do_rast_d    = (state_d == StRIssue);
    do_shade_d   = (state_d == StSIssue);
    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      id_q         <= '0;
      num_q        <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      vox_rd_q     <= 1'b0;
      vox_addr_q   <= '0;
      do_rast_q    <= 1'b0;
      do_shade_q   <= 1'b0;
      voxel_x_q    <= '0;
      voxel_y_q    <= '0;
      voxel_z_q    <= '0;
      voxel_id_q   <= '0;
      palette_q    <= '0;
      fb_valid_q   <= 1'b0;
      fb_row_q     <= '0;
      fb_col_q     <= '0;
      fb_pixel_q   <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      num_q        <= num_d;
      wait_q       <= wait_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      vox_rd_q     <= vox_rd_d;
      vox_addr_q   <= vox_addr_d;
      do_rast_q    <= do_rast_d;
      do_shade_q   <= do_shade_d;
      voxel_x_q    <= voxel_x_d;
      voxel_y_q    <= voxel_y_d;
      voxel_z_q    <= voxel_z_d;
      voxel_id_q   <= voxel_id_d;
      palette_q    <= palette_d;
      fb_valid_q   <= fb_valid_d;
      fb_row_q     <= fb_row_d;
      fb_col_q     <= fb_col_d;
      fb_pixel_q   <= fb_pixel_d;
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign error         = error_q;
  assign vox_rd        = vox_rd_q;
  assign vox_addr      = vox_addr_q;
  assign do_rasterize  = do_rast_q;
  assign do_shade      = do_shade_q;
  assign voxel_x       = voxel_x_q;
  assign voxel_y       = voxel_y_q;
  assign voxel_z       = voxel_z_q;
  assign voxel_id      = voxel_id_q;
  assign palette_entry = palette_q;
  assign fb_valid      = fb_valid_q;
  assign fb_row        = fb_row_q;
  assign fb_col        = fb_col_q;
  assign fb_pixel      = fb_pixel_q;

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Drives one frame through the pixel-shader array. It streams every voxel from voxel memory to all shaders in a rasterize pass, then streams every voxel's colour in a shade pass. It then scans the shader grid by row/col over the shared pixel bus and writes each pixel to the framebuffer through a valid/ready port. It is the initiator side of the shader broadcast protocol and sits between the host command block and the shader array.

## Interface
- ROWS, 4: shader grid rows
- COLS, 4: shader grid columns
- ROW_BITS, 8: row index width
- COL_BITS, 8: col index width
- COORD_BITS, 8: voxel coordinate width
- PALETTE_BITS, 8: voxel id / voxel address width
- PIXEL_BITS, 8: pixel/colour width
- TIMEOUT, 255: maximum number of cycles to wait for a shader done
- clock  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle frame request; ignored while busy
- num_voxels  in  PALETTE_BITS  voxel count, sampled on accepted start
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse at frame end
- error  out  1  sticky timeout flag; cleared on accepted start
- vox_rd  out  1  voxel memory read strobe
- vox_addr  out  PALETTE_BITS  read address, equal to voxel id
- vox_x, vox_y, vox_z  in  COORD_BITS each  read data, valid the cycle after vox_rd
- vox_color  in  PIXEL_BITS  read data, valid the cycle after vox_rd
- do_rasterize  out  1  broadcast rasterize pulse
- do_shade  out  1  broadcast shade pulse
- voxel_x, voxel_y, voxel_z  out  COORD_BITS each  broadcast voxel coordinates
- voxel_id  out  PALETTE_BITS  broadcast voxel id
- palette_entry  out  PIXEL_BITS  broadcast colour
- rasterizing_done  in  1  AND of all shader rasterizing_done signals
- shading_done  in  1  AND of all shader shading_done signals
- row  out  ROW_BITS  pixel bus select
- col  out  COL_BITS  pixel bus select
- pixel  in  PIXEL_BITS  shared pixel bus
- fb_valid  out  1  framebuffer write request
- fb_ready  in  1  framebuffer accept
- fb_row  out  ROW_BITS  write coordinate
- fb_col  out  COL_BITS  write coordinate
- fb_pixel  out  PIXEL_BITS  write data

## Operation
- All outputs are registered. Reset value of every output is 0, including error.
- States:
  - IDLE
  - R_FETCH, R_LOAD, R_ISSUE, R_WAIT (rasterize pass)
  - S_FETCH, S_LOAD, S_ISSUE, S_WAIT (shade pass)
  - RD_ADDR, RD_WRITE (readout)
  - DONE
- IDLE: when start is high, latch num_voxels, set id to 0, clear error, set busy.
  - Go to R_FETCH if num_voxels is non-zero; otherwise go to RD_ADDR.
- R_FETCH: vox_rd=1, vox_addr=id.
- R_LOAD: capture vox_x/y/z into voxel_x/y/z and id into voxel_id.
- R_ISSUE: do_rasterize=1 for exactly one cycle.
- R_WAIT: wait for rasterizing_done.
  - When it arrives, increment id.
  - If id == num_voxels, reset id to 0 and go to S_FETCH; otherwise go to R_FETCH.
- The shade pass is identical to the rasterize pass, with these differences:
  - S_LOAD captures vox_color into palette_entry.
  - S_ISSUE pulses do_shade.
  - S_WAIT waits for shading_done.
  - At the end of the pass, go to RD_ADDR with row=col=0.
- voxel_x/y/z, voxel_id and palette_entry stay stable from the LOAD state until the corresponding done is seen. Shaders read them combinationally throughout their computation.
- RD_ADDR: row/col are stable during this state.
  - At the end of the cycle, capture pixel into fb_pixel, and row/col into fb_row/fb_col.
  - Set fb_valid and go to RD_WRITE.
- RD_WRITE: hold fb_valid and all fb_* outputs until fb_ready is high.
  - On the handshake, drop fb_valid and advance col.
  - When col wraps at COLS-1, reset col to 0 and increment row.
  - After (ROWS-1, COLS-1) go to DONE; otherwise go to RD_ADDR.
- DONE: pulse frame_done, clear busy, go to IDLE.
- Timeout:
  - A wait counter clears on entry to R_WAIT/S_WAIT and increments each cycle spent waiting.
  - When it reaches TIMEOUT: set error, go to DONE (frame_done still pulses), and skip the readout.
- start is ignored in every state except IDLE.
- A done input seen outside R_WAIT/S_WAIT is ignored.
- reset in any state: state returns to IDLE and all outputs go to 0 on the next edge. The shader array shares reset, so both ends restart consistently.

## Timing
- Each voxel costs 3 cycles (FETCH, LOAD, ISSUE) plus the shader latency until done.
- do_rasterize is high in the cycle after R_LOAD. The shader leaves IDLE on the following edge.
- Readout takes a minimum of 2 cycles per pixel with fb_ready held high.
- Readout order is row-major; exactly ROWS*COLS writes per frame.
- busy rises the cycle after start and falls in the cycle after the frame_done pulse.

## Structure
- A shared package holds:
  - the sequencer state enum;
  - a voxel record struct (x, y, z, color);
  - the default widths.
- One sub-module, grid_scan_counter, provides the row/col counter with wrap and a last flag, parameterised by ROWS/COLS.

## Test plan
- Single voxel: num_voxels=1, voxel memory addr 0 holds (2,3,4,0x5A), shader model returns done after 20 cycles.
  - Expect one do_rasterize pulse with voxel_x/y/z=2/3/4 and voxel_id=0, held until done.
  - Expect one do_shade with palette_entry=0x5A.
  - Expect 16 framebuffer writes in row-major order, then frame_done.
- Empty frame: num_voxels=0 -> no vox_rd, no do_rasterize, no do_shade; 16 framebuffer writes; frame_done; error=0.
- Ordering: num_voxels=3 -> vox_addr sequence 0,1,2 in each pass; start pulsed mid-frame is ignored.
- Backpressure: fb_ready held low for 5 cycles at (1,2) -> fb_valid and fb_pixel/fb_row/fb_col held; no pixel skipped or duplicated.
- Timeout: rasterizing_done never asserted -> error=1 after 255 wait cycles, frame_done pulses, no framebuffer writes; the next start clears error.
- Reset mid-R_WAIT -> all outputs 0 next cycle; a subsequent start completes a normal frame.
